// File: rtl/picture_pkg.sv
// picture_pkg: shared definitions for the picture BRAM write-side loader.
//   - default frame geometry and inter-byte timeout
//   - load_state_t: FSM state, encoded so it doubles as the done[1:0] code
//   - pack_pixel(): 3 x 8-bit RGB -> 18-bit {R[7:2],G[7:2],B[7:2]}
package picture_pkg;

  localparam int PIXELS_DEF  = 307200;  // 640x480
  localparam int ADDR_W_DEF  = 19;
  localparam int TIMEOUT_DEF = 20000;
  localparam int PIX_W       = 18;

  // done[1:0] codes seen by the top level and the display side
  localparam logic [1:0] DONE_IDLE     = 2'b00;
  localparam logic [1:0] DONE_LOADING  = 2'b01;
  localparam logic [1:0] DONE_COMPLETE = 2'b10;
  localparam logic [1:0] DONE_ERROR    = 2'b11;

  // State encoding equals the done code, so done is just the state register.
  typedef enum logic [1:0] {
    IDLE     = DONE_IDLE,
    LOAD     = DONE_LOADING,
    COMPLETE = DONE_COMPLETE,
    ERROR    = DONE_ERROR
  } load_state_t;

  // Keep the 6 MSBs of each channel.
  function automatic logic [PIX_W-1:0] pack_pixel(input logic [7:0] r,
                                                  input logic [7:0] g,
                                                  input logic [7:0] b);
    return {r[7:2], g[7:2], b[7:2]};
  endfunction

endpackage

// File: rtl/rx_gap_timer.sv
// rx_gap_timer: counts clk cycles while enabled and flags when the gap
// between received bytes reaches TIMEOUT cycles.
// Ports:
//   clk      in   system clock
//   reset    in   synchronous active-high reset
//   enable   in   count while high; counter is held at zero while low
//   clear    in   restart the count (a byte arrived); overrides expiry
//   expired  out  high in the cycle whose closing edge would bring the
//                 count to TIMEOUT
module rx_gap_timer #(
  parameter int TIMEOUT = 20000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear || !enable) begin
      count_d = '0;
    end else begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // A byte arriving in the expiry cycle wins, hence the !clear term.
  assign expired = enable && !clear && (count_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/picture_load_ctrl.sv
// picture_load_ctrl: write-side sequencer for the picture BRAM (side A).
// Collects R,G,B bytes from the UART receiver, packs each triple into an
// 18-bit pixel and writes it at sequential addresses 0..PIXELS-1.
// Ports:
//   clk        in   system clock, all logic on posedge
//   reset      in   synchronous active-high reset
//   rx_data    in   received byte, valid with rx_ready
//   rx_ready   in   one-cycle byte strobe
//   rearm      in   one-cycle pulse: drop the current frame, back to IDLE
//   we         out  one-cycle BRAM write enable per pixel
//   w_address  out  BRAM write address (held between writes)
//   w_data     out  packed pixel {R[7:2],G[7:2],B[7:2]} (held between writes)
//   done       out  00 IDLE, 01 LOADING, 10 COMPLETE, 11 ERROR
module picture_load_ctrl
  import picture_pkg::*;
#(
  parameter int PIXELS  = PIXELS_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_ready,
  input  logic              rearm,
  output logic              we,
  output logic [ADDR_W-1:0] w_address,
  output logic [PIX_W-1:0]  w_data,
  output logic [1:0]        done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);

  load_state_t       state_q, state_d;
  logic [1:0]        phase_q, phase_d;
  logic [7:0]        r_q, r_d;
  logic [7:0]        g_q, g_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] w_address_q, w_address_d;
  logic [PIX_W-1:0]  w_data_q, w_data_d;

  logic timer_en;
  logic timer_clr;
  logic timer_expired;

  // Only a partially received pixel can time out; between pixels the
  // sender may pause indefinitely.
  assign timer_en  = (state_q == LOAD) && (phase_q != 2'd0);
  assign timer_clr = rx_ready || rearm;

  rx_gap_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_gap_timer (
    .clk     (clk),
    .reset   (reset),
    .enable  (timer_en),
    .clear   (timer_clr),
    .expired (timer_expired)
  );

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    r_d         = r_q;
    g_d         = g_q;
    index_d     = index_q;
    we_d        = 1'b0;
    w_address_d = w_address_q;
    w_data_d    = w_data_q;

    if (rearm) begin
      // Overrides any byte in the same cycle; last written address/data stay visible.
      state_d = IDLE;
      phase_d = 2'd0;
      index_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rx_ready) begin
            r_d     = rx_data;
            phase_d = 2'd1;
            state_d = LOAD;
          end
        end
        LOAD: begin
          if (rx_ready) begin
            unique case (phase_q)
              2'd0: begin
                r_d     = rx_data;
                phase_d = 2'd1;
              end
              2'd1: begin
                g_d     = rx_data;
                phase_d = 2'd2;
              end
              default: begin
                we_d        = 1'b1;
                w_address_d = index_q;
                w_data_d    = pack_pixel(r_q, g_q, rx_data);
                phase_d     = 2'd0;
                // Final pixel: go COMPLETE with the write so done flips
                // in the same cycle we is high. Index is left saturated.
                if (index_q == LAST_ADDR) begin
                  state_d = COMPLETE;
                end else begin
                  index_d = index_q + ADDR_W'(1);
                end
              end
            endcase
          end else if (timer_expired) begin
            state_d = ERROR;
            phase_d = 2'd0;
          end
        end
        COMPLETE: ;
        ERROR: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      phase_q     <= 2'd0;
      r_q         <= '0;
      g_q         <= '0;
      index_q     <= '0;
      we_q        <= 1'b0;
      w_address_q <= '0;
      w_data_q    <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      r_q         <= r_d;
      g_q         <= g_d;
      index_q     <= index_d;
      we_q        <= we_d;
      w_address_q <= w_address_d;
      w_data_q    <= w_data_d;
    end
  end

  assign we        = we_q;
  assign w_address = w_address_q;
  assign w_data    = w_data_q;
  assign done      = state_q;

endmodule

// File: tb/tb_picture_load_ctrl.sv
// Directed bench for picture_load_ctrl with a 4-pixel frame and a 50-cycle
// inter-byte timeout. Inputs change 1 ns after a rising edge and outputs are
// sampled at that same point, i.e. they show the result of that edge.
module tb_picture_load_ctrl;

  localparam int PIXELS  = 4;
  localparam int ADDR_W  = 19;
  localparam int TIMEOUT = 50;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_ready = 1'b0;
  logic              rearm = 1'b0;
  logic              we;
  logic [ADDR_W-1:0] w_address;
  logic [17:0]       w_data;
  logic [1:0]        done;

  int n_vec  = 0;
  int n_miss = 0;
  int we_cnt = 0;
  int we_base;

  // Four pixels with hand-packed {R[7:2],G[7:2],B[7:2]} values.
  logic [7:0]  px_r   [4] = '{8'hFF, 8'h04, 8'h13, 8'hC3};
  logic [7:0]  px_g   [4] = '{8'h00, 8'h08, 8'hA7, 8'hFC};
  logic [7:0]  px_b   [4] = '{8'h80, 8'h0C, 8'h6E, 8'h01};
  logic [17:0] px_exp [4] = '{18'h3F020, 18'h01083, 18'h04A5B, 18'h30FC0};

  picture_load_ctrl #(
    .PIXELS  (PIXELS),
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .rearm     (rearm),
    .we        (we),
    .w_address (w_address),
    .w_data    (w_data),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Counts write pulses; a pulse seen after edge N is counted at edge N+1.
  always @(posedge clk) begin
    if (we) we_cnt <= we_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask

  task automatic pulse_rearm();
    rearm = 1'b1;
    tick();
    rearm = 1'b0;
  endtask

  task automatic send_pixel(input int p);
    send_byte(px_r[p]);
    send_byte(px_g[p]);
    send_byte(px_b[p]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tick();
    tick();
    chk("rst_we", we, 0);
    chk("rst_addr", w_address, 0);
    chk("rst_data", w_data, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;
    tick();

    // 1. single pixel 5A,3C,F0
    send_byte(8'h5A);
    chk("t1_done_load", done, 1);
    send_byte(8'h3C);
    chk("t1_no_we_early", we, 0);
    send_byte(8'hF0);
    chk("t1_we", we, 1);
    chk("t1_addr", w_address, 0);
    chk("t1_data", w_data, 18'h163FC);
    chk("t1_done", done, 1);
    tick();
    chk("t1_we_drop", we, 0);
    chk("t1_data_hold", w_data, 18'h163FC);

    // 2. full frame of 4 pixels, then a stray 13th byte
    pulse_rearm();
    chk("t2_rearm_done", done, 0);
    we_base = we_cnt;
    for (int p = 0; p < PIXELS; p++) begin
      send_pixel(p);
      chk($sformatf("t2_we_p%0d", p), we, 1);
      chk($sformatf("t2_addr_p%0d", p), w_address, p);
      chk($sformatf("t2_data_p%0d", p), w_data, px_exp[p]);
      chk($sformatf("t2_done_p%0d", p), done, (p == PIXELS - 1) ? 2 : 1);
    end
    send_byte(8'h77);
    chk("t2_13th_no_we", we, 0);
    chk("t2_13th_done", done, 2);
    chk("t2_we_count", we_cnt - we_base, 4);
    chk("t2_addr_hold", w_address, 3);

    // 3. timeout after two bytes
    pulse_rearm();
    chk("t3_rearm_done", done, 0);
    we_base = we_cnt;
    send_byte(8'h11);
    send_byte(8'h22);
    idle(49);
    chk("t3_done_49", done, 1);
    tick();
    chk("t3_done_50", done, 3);
    idle(10);
    send_byte(8'h33);
    chk("t3_err_no_we", we, 0);
    chk("t3_err_done", done, 3);
    chk("t3_we_count", we_cnt - we_base, 0);
    pulse_rearm();
    chk("t3_rearm_done2", done, 0);
    chk("t3_rearm_we", we, 0);
    send_pixel(1);
    chk("t3_we", we, 1);
    chk("t3_addr", w_address, 0);
    chk("t3_data", w_data, px_exp[1]);

    // 4. rearm coincident with the B byte
    send_byte(8'hAA);
    send_byte(8'hBB);
    rx_data  = 8'hCC;
    rx_ready = 1'b1;
    rearm    = 1'b1;
    tick();
    rx_ready = 1'b0;
    rearm    = 1'b0;
    chk("t4_no_we", we, 0);
    chk("t4_done", done, 0);
    tick();
    chk("t4_no_we_late", we, 0);
    send_pixel(2);
    chk("t4_we", we, 1);
    chk("t4_addr", w_address, 0);
    chk("t4_data", w_data, px_exp[2]);

    // 5. reset after pixel 2 of 4
    send_pixel(3);
    chk("t5_addr1", w_address, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_rst_we", we, 0);
    chk("t5_rst_addr", w_address, 0);
    chk("t5_rst_data", w_data, 0);
    chk("t5_rst_done", done, 0);
    send_pixel(0);
    chk("t5_we", we, 1);
    chk("t5_addr", w_address, 0);
    chk("t5_done", done, 1);

    // 6. bytes spaced 49 cycles apart, then a byte landing on the expiry cycle
    pulse_rearm();
    send_byte(8'h5A);
    idle(48);
    chk("t6_gap1_done", done, 1);
    send_byte(8'h3C);
    idle(49);
    chk("t6_gap2_done", done, 1);
    send_byte(8'hF0);
    chk("t6_we", we, 1);
    chk("t6_addr", w_address, 0);
    chk("t6_data", w_data, 18'h163FC);
    chk("t6_done", done, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
